// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: ALU results win outright, load and multiply
// share the remaining slot round-robin, and a pending mask tracks outstanding long-latency writes.
module writeback_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    input  logic        mul_valid,
    output logic        mul_ready,
    input  logic [4:0]  mul_addr,
    input  logic [31:0] mul_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    output logic        reg_write,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    output logic [31:0] pending
);

    typedef enum logic {
        RR_LOAD,
        RR_MUL
    } rr_state_t;

    rr_state_t   rr_q;
    rr_state_t   rr_d;
    logic        acc_valid;
    logic        slow_acc;
    logic [4:0]  acc_addr;
    logic [31:0] acc_data;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] pending_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= RR_LOAD;
        end else begin
            rr_q <= rr_d;
        end
    end

    // The ALU has no ready, so it always takes the slot; the slow ports only
    // contend when the ALU is idle, and rr state moves only on a slow grant.
    always_comb begin
        rr_d      = rr_q;
        ld_ready  = 1'b0;
        mul_ready = 1'b0;
        acc_valid = 1'b0;
        slow_acc  = 1'b0;
        acc_addr  = 5'd0;
        acc_data  = 32'd0;
        if (!reset) begin
            if (alu_valid) begin
                acc_valid = 1'b1;
                acc_addr  = alu_addr;
                acc_data  = alu_data;
            end else if (ld_valid && (!mul_valid || rr_q == RR_LOAD)) begin
                ld_ready  = 1'b1;
                acc_valid = 1'b1;
                slow_acc  = 1'b1;
                acc_addr  = ld_addr;
                acc_data  = ld_data;
                rr_d      = RR_MUL;
            end else if (mul_valid) begin
                mul_ready = 1'b1;
                acc_valid = 1'b1;
                slow_acc  = 1'b1;
                acc_addr  = mul_addr;
                acc_data  = mul_data;
                rr_d      = RR_LOAD;
            end
        end
    end

    // Set wins over clear on the same index; bit 0 can never be outstanding.
    always_comb begin
        set_mask  = issue_valid ? (32'h1 << issue_addr) : 32'h0;
        clr_mask  = slow_acc ? (32'h1 << acc_addr) : 32'h0;
        pending_d = ((pending & ~clr_mask) | set_mask) & ~32'h1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 32'h0;
        end else begin
            pending <= pending_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write  <= 1'b0;
            write_addr <= 5'd0;
            write_data <= 32'd0;
        end else begin
            reg_write <= acc_valid && (acc_addr != 5'd0);
            if (acc_valid && (acc_addr != 5'd0)) begin
                write_addr <= acc_addr;
                write_data <= acc_data;
            end
        end
    end

`ifndef SYNTHESIS
    // Upstream must hold a stalled slow result steady until it is taken.
    ld_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (ld_valid && !ld_ready) |=> (ld_valid && $stable(ld_addr) && $stable(ld_data)));
    mul_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (mul_valid && !mul_ready) |=> (mul_valid && $stable(mul_addr) && $stable(mul_data)));
`endif

endmodule
